// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the instruction-ROM loader.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DONE
    } state_t;

    localparam int WORD_BYTES    = 4;
    localparam int DEF_MAX_WORDS = 64;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and instruction-memory write bundle of the loader.
// slave is the loader side; master is the stream source / memory side.
interface rom_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              i_start;
    logic [7:0]        i_byte_in;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_pipe_hold;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start, i_byte_in, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        output o_pipe_hold, o_done, o_err
    );

    modport master (
        output i_start, i_byte_in, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        input  o_pipe_hold, o_done, o_err
    );

endinterface

// File: rtl/rom_loader_byte_packer.sv
// Shifts accepted bytes MSB-first into a word; o_word_vld pulses the cycle after the 4th byte.
// No backpressure of its own: the caller only strobes i_vld on accepted bytes.
module rom_loader_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              R,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [7:0]        i_byte,
    output logic [1:0]        o_cnt,
    output logic              o_word_vld,
    output logic [DATA_W-1:0] o_word
);

    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_vld;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= i_vld && (r_cnt == 2'd3);
            if (i_clr) begin
                r_cnt <= 2'd0;
            end else if (i_vld) begin
                r_shift <= {r_shift[DATA_W-9:0], i_byte};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_word_vld = r_vld;
    assign o_word     = r_shift;

endmodule

// File: rtl/rom_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, holding the pipeline meanwhile;
// wr_en follows the 4th byte by one cycle. ROM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic         clk,
    input  logic         R,
    rom_loader_if.slave  bus
);

    localparam logic [8:0]      LP_MAX  = 9'(MAX_WORDS);
    localparam logic [ADDR_W:0] LP_STEP = (ADDR_W + 1)'(WORD_BYTES);

    state_t            r_state, w_next;
    logic              r_byte_ready, r_wr_en, r_pipe_hold, r_done, r_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [7:0]        r_len, r_word_cnt;
    logic [ADDR_W:0]   r_addr;
    logic              w_acc, w_clr, w_last_word, w_last_byte, w_wr;
    logic              w_set_err, w_rdy_next, w_pk_vld;
    logic [1:0]        w_pk_cnt;
    logic [DATA_W-1:0] w_pk_word;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_acc       = bus.i_byte_valid && r_byte_ready;
    assign w_clr       = (r_state == IDLE) && bus.i_start;
    assign w_last_word = (r_word_cnt == r_len - 8'd1);
    // Drop ready right after the final byte of the last (or wrapped) word so nothing
    // else enters the packer before the FSM leaves DATA on the following edge.
    assign w_last_byte = w_acc && (r_state == DATA) && (w_pk_cnt == 2'd3)
                         && (w_last_word || r_addr[ADDR_W]);
    assign w_wr        = w_pk_vld && (r_state == DATA) && !r_addr[ADDR_W];

    rom_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .R          (R),
        .i_clr      (w_clr),
        .i_vld      (w_acc && (r_state == DATA)),
        .i_byte     (bus.i_byte_in),
        .o_cnt      (w_pk_cnt),
        .o_word_vld (w_pk_vld),
        .o_word     (w_pk_word)
    );

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            IDLE: if (bus.i_start) w_next = LEN;
            LEN: if (w_acc) begin
                if (bus.i_byte_in == 8'd0) begin
                    w_next = DONE;
                end else if ({1'b0, bus.i_byte_in} > LP_MAX) begin
                    w_next    = DONE;
                    w_set_err = 1'b1;
                end else begin
                    w_next = DATA;
                end
            end
            DATA: if (w_pk_vld) begin
                if (r_addr[ADDR_W]) begin
                    w_next    = DONE;
                    w_set_err = 1'b1;
                end else if (w_last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    w_next = CHK;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CHK: if (w_acc) begin
                w_next    = DONE;
                w_set_err = (bus.i_byte_in != r_csum);
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_rdy_next = (w_next == LEN) || (w_next == CHK)
                     || ((w_next == DATA) && !w_last_byte);
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_pipe_hold  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= 8'd0;
            r_word_cnt   <= 8'd0;
            r_addr       <= '0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= w_rdy_next;
            r_wr_en      <= w_wr;
            if (w_wr) begin
                r_wr_addr <= r_addr[ADDR_W-1:0];
                r_wr_data <= w_pk_word;
            end
            if (w_pk_vld && (r_state == DATA)) begin
                r_addr     <= r_addr + LP_STEP;
                r_word_cnt <= r_word_cnt + 8'd1;
            end
            if ((r_state == LEN) && w_acc) begin
                r_len      <= bus.i_byte_in;
                r_word_cnt <= 8'd0;
                r_addr     <= {1'b0, BASE_ADDR};
            end
            if (w_clr) begin
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_pipe_hold <= 1'b1;
            end
            if (w_set_err) r_err <= 1'b1;
            if ((w_next == DONE) && (r_state != DONE)) begin
                r_done      <= 1'b1;
                r_pipe_hold <= 1'b0;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge R) begin
        if (R)                                   r_csum <= 8'd0;
        else if (w_clr)                          r_csum <= 8'd0;
        else if (w_acc && (r_state == DATA))     r_csum <= r_csum ^ bus.i_byte_in;
    end
`endif

    assign bus.o_byte_ready = r_byte_ready;
    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_wr_addr    = r_wr_addr;
    assign bus.o_wr_data    = r_wr_data;
    assign bus.o_pipe_hold  = r_pipe_hold;
    assign bus.o_done       = r_done;
    assign bus.o_err        = r_err;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected writes are queued as bytes are sent and
// popped by a monitor that checks address, data and the one-cycle write latency.
module tb_rom_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic R   = 1'b1;
    always #5 clk = ~clk;

    rom_loader_if bus ();
    rom_loader dut (.clk(clk), .R(R), .bus(bus));

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_wr = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] wmem [64];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.o_wr_en === 1'b1) begin
            n_wr      = n_wr + 1;
            last_addr = bus.o_wr_addr;
            n_chk     = n_chk + 1;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, want no write", bus.o_wr_addr, bus.o_wr_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.o_wr_addr !== mon_e.addr || bus.o_wr_data !== mon_e.data || cyc !== mon_e.cyc)
                    $display("FAIL write: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             bus.o_wr_addr, bus.o_wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                else
                    n_pass = n_pass + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(posedge clk); #1 bus.i_start = 1'b1;
        @(posedge clk); #1 bus.i_start = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubble, input bit pulse_start, output bit ok);
        bit got;
        got = 1'b0;
        if (bubble) begin
            bus.i_byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_byte_valid = 1'b1;
        bus.i_byte_in    = b;
        bus.i_start      = pulse_start;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.o_byte_ready === 1'b1) begin
                @(posedge clk); #1;
                got = 1'b1;
            end
        end
        bus.i_byte_valid = 1'b0;
        bus.i_start      = 1'b0;
        ok = got;
        if (!got) begin
            n_chk = n_chk + 1;
            $display("FAIL byte_timeout: byte=%h ready=0, want ready=1 within 50 cycles", b);
        end
    endtask

    // Sends N then nw words from wmem; stops before byte index stop_after (if >= 0).
    task automatic load(input logic [7:0] n, input int nw, input bit bub, input bit skip_start,
                        input int stop_after, input int start_at, input bit bad_csum);
        logic [7:0]  cs, b;
        logic [31:0] w;
        bit          ok;
        int          idx;
        cs  = 8'h00;
        idx = 0;
        if (!skip_start) do_start();
        send_byte(n, 1'b0, 1'b0, ok);
        for (int i = 0; i < nw; i++) begin
            w = wmem[i];
            for (int k = 0; k < 4; k++) begin
                if (idx == stop_after) return;
                b = w[31 - 8*k -: 8];
                send_byte(b, bub, idx == start_at, ok);
                cs = cs ^ b;
                if (k == 3 && ok) sb.push_back('{8'(4*i), w, cyc + 1});
                idx++;
            end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        if (nw > 0) send_byte(cs ^ {7'd0, bad_csum}, bub, 1'b0, ok);
`else
        if (bad_csum) cs = 8'h00;
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.o_byte_ready, bus.o_wr_en, bus.o_pipe_hold, bus.o_done, bus.o_err} !== 5'b0)
            $display("FAIL reset_flags: got rdy/wr/hold/done/err=%b, want 00000",
                     {bus.o_byte_ready, bus.o_wr_en, bus.o_pipe_hold, bus.o_done, bus.o_err});
        else n_pass++;
        n_chk++;
        if (bus.o_wr_addr !== 8'h00) $display("FAIL reset_addr: got %h, want 00", bus.o_wr_addr);
        else n_pass++;
        n_chk++;
        if (bus.o_wr_data !== 32'h0) $display("FAIL reset_data: got %h, want 00000000", bus.o_wr_data);
        else n_pass++;
        R = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.o_byte_ready !== 1'b0) $display("FAIL idle_ready_after_reset: got %b, want 0", bus.o_byte_ready);
        else n_pass++;
    endtask

    task automatic check_end(input string name, input int wr0, input int want_wr, input logic want_err);
        n_chk++;
        if (n_wr - wr0 !== want_wr) $display("FAIL %s_writes: got %0d, want %0d", name, n_wr - wr0, want_wr);
        else n_pass++;
        n_chk++;
        if ({bus.o_done, bus.o_pipe_hold, bus.o_err} !== {1'b1, 1'b0, want_err})
            $display("FAIL %s_status: got done/hold/err=%b, want %b", name,
                     {bus.o_done, bus.o_pipe_hold, bus.o_err}, {1'b1, 1'b0, want_err});
        else n_pass++;
        n_chk++;
        if (sb.size() != 0) $display("FAIL %s_pending: got %0d writes outstanding, want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_basic();
        int wr0;
        wmem[0] = 32'hE3A00005;
        wmem[1] = 32'hE2811001;
        wr0 = n_wr;
        do_start();
        n_chk++;
        if ({bus.o_pipe_hold, bus.o_done, bus.o_err} !== 3'b100)
            $display("FAIL basic_loading: got hold/done/err=%b, want 100", {bus.o_pipe_hold, bus.o_done, bus.o_err});
        else n_pass++;
        load(8'd2, 2, 1'b0, 1'b1, -1, -1, 1'b0);
        settle();
        check_end("basic", wr0, 2, 1'b0);
    endtask

    task automatic test_bubbles();
        int wr0;
        int bad;
        bad = 0;
        bus.i_byte_valid = 1'b1;
        bus.i_byte_in    = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.o_byte_ready !== 1'b0) bad++;
        end
        bus.i_byte_valid = 1'b0;
        n_chk++;
        if (bad != 0) $display("FAIL idle_ready: got ready=1 in %0d idle cycles, want 0", bad);
        else n_pass++;
        wr0 = n_wr;
        load(8'd2, 2, 1'b1, 1'b0, -1, -1, 1'b0);
        settle();
        check_end("bubbles", wr0, 2, 1'b0);
    endtask

    task automatic test_len_bounds();
        int wr0;
        wr0 = n_wr;
        load(8'h00, 0, 1'b0, 1'b0, -1, -1, 1'b0);
        settle();
        check_end("len_zero", wr0, 0, 1'b0);
        wr0 = n_wr;
        load(8'h41, 0, 1'b0, 1'b0, -1, -1, 1'b0);
        settle();
        check_end("len_over", wr0, 0, 1'b1);
    endtask

    task automatic test_full();
        int wr0;
        for (int i = 0; i < 64; i++) wmem[i] = $urandom;
        wr0 = n_wr;
        do_start();
        n_chk++;
        if ({bus.o_pipe_hold, bus.o_done, bus.o_err} !== 3'b100)
            $display("FAIL full_start_clears: got hold/done/err=%b, want 100", {bus.o_pipe_hold, bus.o_done, bus.o_err});
        else n_pass++;
        load(8'h40, 64, 1'b0, 1'b1, -1, -1, 1'b0);
        settle();
        check_end("full", wr0, 64, 1'b0);
        n_chk++;
        if (last_addr !== 8'hFC) $display("FAIL full_last_addr: got %h, want FC", last_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int wr0;
        wmem[0] = $urandom;
        wmem[1] = $urandom;
        wr0 = n_wr;
        load(8'd2, 2, 1'b0, 1'b0, 6, -1, 1'b0);
        R = 1'b1;
        #1;
        n_chk++;
        if ({bus.o_byte_ready, bus.o_wr_en, bus.o_pipe_hold, bus.o_done, bus.o_err, bus.o_wr_addr, bus.o_wr_data} !== '0)
            $display("FAIL midreset_outputs: got rdy/wr/hold/done/err=%b addr=%h data=%h, want all 0",
                     {bus.o_byte_ready, bus.o_wr_en, bus.o_pipe_hold, bus.o_done, bus.o_err}, bus.o_wr_addr, bus.o_wr_data);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 R = 1'b0;
        settle();
        n_chk++;
        if (n_wr - wr0 !== 1) $display("FAIL midreset_writes: got %0d, want 1", n_wr - wr0);
        else n_pass++;
        wr0 = n_wr;
        load(8'd2, 2, 1'b0, 1'b0, -1, -1, 1'b0);
        settle();
        check_end("restart", wr0, 2, 1'b0);
    endtask

    task automatic test_start_busy();
        int wr0;
        wmem[0] = $urandom;
        wmem[1] = $urandom;
        wr0 = n_wr;
        load(8'd2, 2, 1'b0, 1'b0, -1, 5, 1'b0);
        settle();
        check_end("start_busy", wr0, 2, 1'b0);
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int wr0;
        wmem[0] = 32'h11223344;
        wr0 = n_wr;
        load(8'd1, 1, 1'b0, 1'b0, -1, -1, 1'b0);
        settle();
        check_end("csum_good", wr0, 1, 1'b0);
        wr0 = n_wr;
        load(8'd1, 1, 1'b0, 1'b0, -1, -1, 1'b1);
        settle();
        check_end("csum_bad", wr0, 1, 1'b1);
    endtask
`endif

    initial begin
        bus.i_start      = 1'b0;
        bus.i_byte_in    = 8'h00;
        bus.i_byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_len_bounds();
        test_full();
        test_reset_mid();
        test_start_busy();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
